// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bus between the
// instruction-fetch port and the load/store port, with a wait-state timeout.
module mem_bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [3:0]       d_byteen,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic             m_req,
    output logic             m_we,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic [3:0]       m_byteen,
    input  logic [WIDTH-1:0] m_rdata,
    input  logic             m_ready,
    output logic             bus_error
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_reg, state_next;
    logic            last_data_reg;   // 1 when the data port holds (or last held) the bus
    logic            err_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic            grant_fetch, grant_data, timeout;

    // Grant decision, only meaningful while idle; ties go to the port not served last.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_reg == IDLE) begin
            if (i_req && d_req) begin
                grant_fetch = last_data_reg;
                grant_data  = !last_data_reg;
            end else begin
                grant_fetch = i_req;
                grant_data  = d_req;
            end
        end
    end

    // Abort when the counter would reach MAX_WAIT with no ready; ready in that cycle still wins.
    assign timeout = (state_reg == ACCESS) && !m_ready && (wait_cnt_reg == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_fetch || grant_data) state_next = ACCESS;
            ACCESS:  if (m_ready || timeout)        state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_ack     = (state_reg == RESP) && !last_data_reg;
        d_ack     = (state_reg == RESP) && last_data_reg;
        bus_error = (state_reg == RESP) && err_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data_reg <= 1'b1;
            err_reg       <= 1'b0;
            wait_cnt_reg  <= '0;
            m_req         <= 1'b0;
            m_we          <= 1'b0;
            m_addr        <= '0;
            m_wdata       <= '0;
            m_byteen      <= 4'h0;
            i_rdata       <= '0;
            d_rdata       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_fetch) begin
                        last_data_reg <= 1'b0;
                        m_req         <= 1'b1;
                        m_we          <= 1'b0;
                        m_addr        <= i_addr;
                        m_wdata       <= '0;
                        m_byteen      <= 4'hF;
                        wait_cnt_reg  <= '0;
                        err_reg       <= 1'b0;
                    end else if (grant_data) begin
                        last_data_reg <= 1'b1;
                        m_req         <= 1'b1;
                        m_we          <= d_we;
                        m_addr        <= d_addr;
                        m_wdata       <= d_wdata;
                        m_byteen      <= d_byteen;
                        wait_cnt_reg  <= '0;
                        err_reg       <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        if (!last_data_reg) i_rdata <= m_rdata;
                        else if (!m_we)     d_rdata <= m_rdata;
                    end else if (timeout) begin
                        m_req   <= 1'b0;
                        err_reg <= 1'b1;
                        if (!last_data_reg) i_rdata <= '0;
                        else if (!m_we)     d_rdata <= '0;
                    end else if (wait_cnt_reg != CW'(MAX_WAIT)) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Transaction-level bench for mem_bus_arbiter: directed cases from reset, then
// randomized requester/memory traffic against a round-robin timing model.
module tb_mem_bus_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_req = 1'b0;
    logic [WIDTH-1:0] i_addr = '0;
    logic             i_ack;
    logic [WIDTH-1:0] i_rdata;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [WIDTH-1:0] d_addr = '0;
    logic [WIDTH-1:0] d_wdata = '0;
    logic [3:0]       d_byteen = 4'h0;
    logic             d_ack;
    logic [WIDTH-1:0] d_rdata;
    logic             m_req;
    logic             m_we;
    logic [WIDTH-1:0] m_addr;
    logic [WIDTH-1:0] m_wdata;
    logic [3:0]       m_byteen;
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_ready = 1'b0;
    logic             bus_error;

    mem_bus_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteen(d_byteen), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_rdata(m_rdata), .m_ready(m_ready),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int txn_count = 0;

    // Reference state: which port was served last, and what each rdata output should hold.
    logic             model_last_d = 1'b1;
    logic [WIDTH-1:0] exp_i = '0;
    logic [WIDTH-1:0] exp_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'h0, m_req, m_we, i_ack, d_ack, bus_error, 3'b000}, 32'h0);
        check({tag, "_be"}, {28'h0, m_byteen}, 32'h0);
        check({tag, "_addr"}, m_addr, 32'h0);
        check({tag, "_wdata"}, m_wdata, 32'h0);
        check({tag, "_irdata"}, i_rdata, 32'h0);
        check({tag, "_drdata"}, d_rdata, 32'h0);
    endtask

    // Called at a falling edge with the DUT idle; the next rising edge samples the requests.
    // lat = index of the access cycle in which memory raises m_ready (>= MAX_WAIT: never).
    task automatic run_txn(input int lat, input logic [31:0] word, output logic win_d);
        int               acc;
        logic             to;
        logic             e_we;
        logic [31:0]      e_addr, e_wdata, rd;
        logic [3:0]       e_be;
        win_d = (i_req && d_req) ? !model_last_d : d_req;
        model_last_d = win_d;
        if (win_d) begin
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_byteen;
        end else begin
            e_we = 1'b0; e_addr = i_addr; e_wdata = 32'h0; e_be = 4'hF;
        end
        to  = (lat >= MAX_WAIT);
        acc = to ? MAX_WAIT : lat + 1;

        @(negedge clk);
        check("m_req_up", {31'h0, m_req}, 32'h1);
        check("m_we", {31'h0, m_we}, {31'h0, e_we});
        check("m_addr", m_addr, e_addr);
        check("m_wdata", m_wdata, e_wdata);
        check("m_byteen", {28'h0, m_byteen}, {28'h0, e_be});

        // Disturb the granted port's fields (and sometimes its req) to show they are latched.
        if ($urandom_range(0, 3) == 0) begin
            if (win_d) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
                if ($urandom_range(0, 1) == 1) d_req = 1'b0;
            end else begin
                i_addr = $urandom;
                if ($urandom_range(0, 1) == 1) i_req = 1'b0;
            end
        end

        for (int c = 0; c < acc; c++) begin
            m_ready = (c == lat);
            m_rdata = (c == lat) ? word : $urandom;
            @(negedge clk);
            m_ready = 1'b0;
            if (c < acc - 1) begin
                check("m_req_hold", {31'h0, m_req}, 32'h1);
                check("m_addr_hold", m_addr, e_addr);
                check("ack_early", {30'h0, i_ack, d_ack}, 32'h0);
            end
        end

        rd = to ? 32'h0 : word;
        if (!win_d)     exp_i = rd;
        else if (!e_we) exp_d = rd;
        check("m_req_drop", {31'h0, m_req}, 32'h0);
        check("i_ack", {31'h0, i_ack}, {31'h0, !win_d});
        check("d_ack", {31'h0, d_ack}, {31'h0, win_d});
        check("bus_error", {31'h0, bus_error}, {31'h0, to});
        check("i_rdata", i_rdata, exp_i);
        check("d_rdata", d_rdata, exp_d);
        $display("txn %0d: port=%s we=%0d addr=%h lat=%0d timeout=%0d",
                 txn_count, win_d ? "D" : "I", e_we, e_addr, lat, to);
        txn_count++;

        @(negedge clk);
        check("idle_quiet", {28'h0, m_req, i_ack, d_ack, bus_error}, 32'h0);
    endtask

    initial begin
        logic w;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Simultaneous requests from reset, held across acks: alternation starting with fetch.
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'b0011;
        run_txn(0, 32'h0050_0093, w);
        check("tie1_fetch", {31'h0, w}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = 32'h0000_0010;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'b0011;
            run_txn($urandom_range(0, 2), $urandom, w);
        end

        // Hung load, then a slow load, then a store that must not disturb d_rdata, then a fetch.
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_byteen = 4'hF;
        run_txn(1000, $urandom, w);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_byteen = 4'hF;
        run_txn(5, 32'h1234_5678, w);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h208; d_wdata = 32'hCAFE_F00D; d_byteen = 4'hC;
        run_txn(2, 32'hFFFF_FFFF, w);
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h40;
        run_txn(1, 32'hA5A5_0001, w);
        check("store_keeps_drdata", d_rdata, 32'h1234_5678);

        // Reset in the middle of an access clears outputs before the next clock edge.
        i_req = 1'b1; i_addr = 32'h80;
        @(negedge clk);
        check("pre_reset_m_req", {31'h0, m_req}, 32'h1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        reset = 1'b0;
        model_last_d = 1'b1; exp_i = '0; exp_d = '0;
        i_req = 1'b1; i_addr = 32'h84; d_req = 1'b0;
        run_txn(0, 32'h1111_2222, w);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if (!i_req || !w) begin
                i_req = 1'($urandom);
                i_addr = $urandom;
            end
            if (!d_req || w) begin
                d_req = 1'($urandom);
                d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_byteen = 4'($urandom);
            end
            if (!i_req && !d_req) i_req = 1'b1;
            run_txn(($urandom_range(0, 9) == 0) ? MAX_WAIT + $urandom_range(0, 4)
                                                : $urandom_range(0, MAX_WAIT - 1),
                    $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch port (read-only) and data port (load/store).
- Sits between the core datapath/control and the unified memory in the multi-cycle build.
- Arbitrates round-robin, registers the winning request onto the memory bus, and waits for a variable-latency ready.
- Returns data with a one-cycle ack pulse and aborts hung accesses with a timeout error.

Parameters:
WIDTH, 32, address/data width
MAX_WAIT, 16, cycles ACCESS may wait for m_ready before abort (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
i_req  in  1  fetch request; held until i_ack
i_addr  in  WIDTH  fetch address
i_ack  out  1  one-cycle completion pulse, fetch
i_rdata  out  WIDTH  fetched word; valid with i_ack, held until next i_ack
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
d_byteen  in  4  store/load byte enables
d_ack  out  1  one-cycle completion pulse, data
d_rdata  out  WIDTH  load data; valid with d_ack, held until next load d_ack
m_req  out  1  memory request, registered
m_we  out  1  memory write enable
m_addr  out  WIDTH  memory address
m_wdata  out  WIDTH  memory write data
m_byteen  out  4  memory byte enables
m_rdata  in  WIDTH  memory read data, valid when m_ready=1
m_ready  in  1  memory completes current request this cycle
bus_error  out  1  one-cycle pulse coincident with ack of a timed-out access

Behaviour:
- Reset (async, immediate):
  - State IDLE; last_grant = DATA.
  - All outputs 0: m_req, m_we, m_addr, m_wdata, m_byteen, i_ack, d_ack, i_rdata, d_rdata, bus_error.
  - Reset mid-access drops m_req immediately; the transaction is lost and no ack is issued.
- FSM states:
  - IDLE
    - Sample i_req/d_req. Only one set: grant it. Both set: grant the port != last_grant. Neither: stay.
    - On grant: update last_grant; latch the winner's fields into the m_* registers; set m_req=1; clear wait counter; go to ACCESS.
    - Fetch grant drives m_we=0, m_byteen=4'b1111, m_wdata=0.
  - ACCESS
    - m_* outputs held stable.
    - If m_ready=1: capture m_rdata into i_rdata (fetch) or d_rdata (load); stores leave d_rdata unchanged. Set m_req=0; go to RESP.
    - Else increment counter. When the counter reaches MAX_WAIT with m_ready still 0: abort. Set m_req=0, mark error, load 0 into the granted rdata register (loads/fetches only), go to RESP.
  - RESP
    - Granted port's ack=1 for exactly this cycle; bus_error=1 this cycle if aborted.
    - Unconditionally return to IDLE; no new grant is issued in RESP.
- Timing, zero wait states:
  - Request seen in IDLE at cycle 0.
  - m_req=1 in cycle 1; m_ready sampled in cycle 1.
  - Ack in cycle 2; IDLE again in cycle 3.
  - Minimum 3 cycles per transaction. Each extra wait cycle adds 1.
- Handshake:
  - Requesters hold req and fields stable until ack.
  - Field changes after grant are ignored because fields are latched.
  - Req dropped before ack does not cancel; ack is still issued.
  - Req still high in the cycle after ack is treated as a new request.
- Fairness:
  - With both requesters continuously asserted, grants strictly alternate.
  - First tie after reset goes to fetch.
- m_req is never asserted in IDLE or RESP, and at most one transaction is outstanding.
- i_ack and d_ack are never high in the same cycle.
- Wait counter width is $clog2(MAX_WAIT+1); it saturates, with no wrap.

Test Plan:
- Reset, then i_req=1, i_addr=0x0000_0010; memory m_ready=1 on first m_req cycle with m_rdata=0x0050_0093 -> m_req high cycle 1 with m_addr=0x10, m_we=0, m_byteen=4'hF; i_ack pulse cycle 2 with i_rdata=0x0050_0093.
- i_req and d_req asserted together from reset (d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_byteen=4'b0011), held and re-asserted after each ack -> grant order I, D, I, D; D access shows m_we=1, m_wdata=0xDEAD_BEEF, m_byteen=4'b0011.
- Load with m_ready delayed 5 cycles, m_rdata=0x1234_5678 -> m_* stable for 6 ACCESS cycles; d_ack 1 cycle after m_ready; d_rdata=0x1234_5678; bus_error=0.
- Load with m_ready never asserted, MAX_WAIT=16 -> m_req drops after 16 cycles; d_ack and bus_error pulse together; d_rdata=0.
- Store followed by a fetch -> d_rdata retains the prior load value; fetch proceeds normally.
- Assert reset during ACCESS -> all outputs 0 asynchronously, before the next clk edge; no ack; after release, a fresh i_req completes normally.
